// File: rtl/motion_frame_alarm.sv
// Per-pixel motion filter (isolated-pixel suppression along a line), per-frame motion
// counting with threshold, and a debounced frame-level alarm state machine.
module motion_frame_alarm #(
   parameter int CNT_W         = 20,
   parameter int WARMUP_FRAMES = 1,
   parameter int CONSEC_ON     = 3,
   parameter int CONSEC_OFF    = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_enable,
   input  logic             i_pix_valid,
   input  logic             i_sol,
   input  logic             i_sof,
   input  logic             i_eof,
   input  logic             i_motion_detected,
   input  logic [CNT_W-1:0] i_count_threshold,
   output logic             o_mask_valid,
   output logic             o_mask_out,
   output logic             o_frame_done,
   output logic [CNT_W-1:0] o_frame_motion_cnt,
   output logic             o_frame_motion,
   output logic             o_alarm
);

   localparam logic [7:0] LP_WARM = WARMUP_FRAMES[7:0];
   localparam logic [3:0] LP_ON   = CONSEC_ON[3:0];
   localparam logic [3:0] LP_OFF  = CONSEC_OFF[3:0];

   typedef enum logic [2:0] {
      S_WARMUP    = 3'd0,
      S_QUIET     = 3'd1,
      S_ARMING    = 3'd2,
      S_ALARM     = 3'd3,
      S_RELEASING = 3'd4
   } state_t;

   state_t           r_state;
   logic [7:0]       r_warm_cnt;
   logic [3:0]       r_on_cnt;
   logic [3:0]       r_off_cnt;
   logic             r_prev;
   logic [CNT_W-1:0] r_cnt;
   logic             r_mask_valid;
   logic             r_mask_out;
   logic             r_frame_done;
   logic [CNT_W-1:0] r_fm_cnt;
   logic             r_fm;
   logic             r_alarm;

   logic             w_acc;
   logic             w_eof_acc;
   logic             w_f;
   logic [CNT_W-1:0] w_base;
   logic [CNT_W-1:0] w_sum;
   logic             w_is_motion;
   logic [7:0]       w_warm_nxt;
   logic [3:0]       w_on_nxt;
   logic [3:0]       w_off_nxt;

   // A pixel is kept only if the previous pixel of the same line also moved.
   assign w_acc       = i_enable & i_pix_valid;
   assign w_eof_acc   = w_acc & i_eof;
   assign w_f         = i_motion_detected & r_prev & ~(i_sol | i_sof);
   assign w_base      = i_sof ? {CNT_W{1'b0}} : r_cnt;
   assign w_sum       = (&w_base) ? w_base : w_base + {{(CNT_W-1){1'b0}}, w_f};
   assign w_is_motion = (w_sum >= i_count_threshold);
   assign w_warm_nxt  = r_warm_cnt + 8'd1;
   assign w_on_nxt    = r_on_cnt + 4'd1;
   assign w_off_nxt   = r_off_cnt + 4'd1;

   // Pixel filter, mask output and per-frame count capture.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_prev       <= 1'b0;
         r_cnt        <= {CNT_W{1'b0}};
         r_mask_valid <= 1'b0;
         r_mask_out   <= 1'b0;
         r_frame_done <= 1'b0;
         r_fm_cnt     <= {CNT_W{1'b0}};
         r_fm         <= 1'b0;
      end else begin
         r_mask_valid <= w_acc;
         r_mask_out   <= w_acc & w_f;
         r_frame_done <= w_eof_acc;
         if (w_acc) begin
            r_prev <= i_motion_detected;
            r_cnt  <= i_eof ? {CNT_W{1'b0}} : w_sum;
         end
         if (w_eof_acc) begin
            r_fm_cnt <= w_sum;
            r_fm     <= w_is_motion;
         end
      end
   end

   // Alarm debounce FSM; steps once per completed frame, alarm registered alongside.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= S_WARMUP;
         r_warm_cnt <= 8'd0;
         r_on_cnt   <= 4'd0;
         r_off_cnt  <= 4'd0;
         r_alarm    <= 1'b0;
      end else if (w_eof_acc) begin
         case (r_state)
            S_WARMUP: begin
               r_warm_cnt <= w_warm_nxt;
               if (w_warm_nxt >= LP_WARM) begin
                  r_state    <= S_QUIET;
                  r_warm_cnt <= 8'd0;
               end
            end
            S_QUIET: begin
               if (w_is_motion) begin
                  if (LP_ON == 4'd1) begin
                     r_state <= S_ALARM;
                     r_alarm <= 1'b1;
                  end else begin
                     r_state  <= S_ARMING;
                     r_on_cnt <= 4'd1;
                  end
               end
            end
            S_ARMING: begin
               if (w_is_motion) begin
                  if (w_on_nxt >= LP_ON) begin
                     r_state  <= S_ALARM;
                     r_on_cnt <= 4'd0;
                     r_alarm  <= 1'b1;
                  end else begin
                     r_on_cnt <= w_on_nxt;
                  end
               end else begin
                  r_state  <= S_QUIET;
                  r_on_cnt <= 4'd0;
               end
            end
            S_ALARM: begin
               if (!w_is_motion) begin
                  if (LP_OFF == 4'd1) begin
                     r_state <= S_QUIET;
                     r_alarm <= 1'b0;
                  end else begin
                     r_state   <= S_RELEASING;
                     r_off_cnt <= 4'd1;
                  end
               end
            end
            S_RELEASING: begin
               if (w_is_motion) begin
                  r_state   <= S_ALARM;
                  r_off_cnt <= 4'd0;
               end else if (w_off_nxt >= LP_OFF) begin
                  r_state   <= S_QUIET;
                  r_off_cnt <= 4'd0;
                  r_alarm   <= 1'b0;
               end else begin
                  r_off_cnt <= w_off_nxt;
               end
            end
            default: begin
               r_state <= S_WARMUP;
               r_alarm <= 1'b0;
            end
         endcase
      end
   end

   assign o_mask_valid       = r_mask_valid;
   assign o_mask_out         = r_mask_out;
   assign o_frame_done       = r_frame_done;
   assign o_frame_motion_cnt = r_fm_cnt;
   assign o_frame_motion     = r_fm;
   assign o_alarm            = r_alarm;

endmodule

// File: tb/tb_motion_frame_alarm.sv
// Scoreboard bench for motion_frame_alarm: directed pixel streams push expected masks
// and frame results; a negedge monitor pops and compares whenever the DUT presents them.
module tb_motion_frame_alarm;

   logic        clk = 1'b0;
   logic        rst, enable, pix_valid, sol, sof, eof, md;
   logic [19:0] thr;
   logic        mask_valid, mask_out, frame_done, frame_motion, alarm;
   logic [19:0] frame_motion_cnt;

   typedef struct {
      logic [19:0] cnt;
      logic        fm;
      logic        al;
   } frm_t;

   logic  exp_mask_q[$];
   frm_t  exp_frm_q[$];
   int    n_cmp = 0;
   int    n_err = 0;
   int    chk_req = 0;
   logic [19:0] chk_cnt;
   logic  chk_fm, chk_al;
   bit    tb_done = 1'b0;

   always #5 clk = ~clk;

   motion_frame_alarm dut (
      .i_clk              (clk),
      .i_rst              (rst),
      .i_enable           (enable),
      .i_pix_valid        (pix_valid),
      .i_sol              (sol),
      .i_sof              (sof),
      .i_eof              (eof),
      .i_motion_detected  (md),
      .i_count_threshold  (thr),
      .o_mask_valid       (mask_valid),
      .o_mask_out         (mask_out),
      .o_frame_done       (frame_done),
      .o_frame_motion_cnt (frame_motion_cnt),
      .o_frame_motion     (frame_motion),
      .o_alarm            (alarm)
   );

   // Monitor: owns all comparison counters.
   initial begin : monitor
      int   chk_seen;
      logic m;
      frm_t f;
      chk_seen = 0;
      forever begin
         @(negedge clk);
         if (mask_valid) begin
            n_cmp++;
            if (exp_mask_q.size() == 0) begin
               n_err++;
               $display("FAIL mask_unexpected: got mask_valid=1 mask_out=%0b, required no mask", mask_out);
            end else begin
               m = exp_mask_q.pop_front();
               if (mask_out !== m) begin
                  n_err++;
                  $display("FAIL mask_out @%0t: got %0b required %0b", $time, mask_out, m);
               end
            end
         end
         if (frame_done) begin
            if (exp_frm_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL frame_done_unexpected: got frame_done=1 cnt=%0d, required none", frame_motion_cnt);
            end else begin
               f = exp_frm_q.pop_front();
               n_cmp++;
               if (frame_motion_cnt !== f.cnt) begin
                  n_err++;
                  $display("FAIL frame_cnt @%0t: got %0d required %0d", $time, frame_motion_cnt, f.cnt);
               end
               n_cmp++;
               if (frame_motion !== f.fm) begin
                  n_err++;
                  $display("FAIL frame_motion @%0t: got %0b required %0b", $time, frame_motion, f.fm);
               end
               n_cmp++;
               if (alarm !== f.al) begin
                  n_err++;
                  $display("FAIL alarm_at_done @%0t: got %0b required %0b", $time, alarm, f.al);
               end
            end
         end
         if (chk_req != chk_seen) begin
            chk_seen = chk_req;
            n_cmp++;
            if (frame_motion_cnt !== chk_cnt || frame_motion !== chk_fm || alarm !== chk_al ||
                mask_valid !== 1'b0 || mask_out !== 1'b0 || frame_done !== 1'b0) begin
               n_err++;
               $display("FAIL hold_check #%0d: got cnt=%0d fm=%0b al=%0b mv=%0b mo=%0b fd=%0b required cnt=%0d fm=%0b al=%0b mv=0 mo=0 fd=0",
                        chk_seen, frame_motion_cnt, frame_motion, alarm, mask_valid, mask_out,
                        frame_done, chk_cnt, chk_fm, chk_al);
            end
         end
         if (tb_done) begin
            n_cmp++;
            if (exp_mask_q.size() != 0 || exp_frm_q.size() != 0) begin
               n_err++;
               $display("FAIL drain: got %0d masks / %0d frames outstanding, required 0 / 0",
                        exp_mask_q.size(), exp_frm_q.size());
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
            $finish;
         end
      end
   end

   task automatic px(input logic en, input logic s_l, input logic s_f, input logic e_f,
                     input logic bit_in, input logic exp_m);
      enable = en; pix_valid = 1'b1; sol = s_l; sof = s_f; eof = e_f; md = bit_in;
      if (en) exp_mask_q.push_back(exp_m);
      @(posedge clk); #1;
      enable = 1'b0; pix_valid = 1'b0; sol = 1'b0; sof = 1'b0; eof = 1'b0; md = 1'b0;
   endtask

   // Bits and expected masks are listed LSB-first in pixel order.
   task automatic seq(input int n, input logic [15:0] bits, input logic [15:0] expm,
                      input bit sof_first, input bit eof_last);
      for (int i = 0; i < n; i++)
         px(1'b1, (i == 0), (sof_first && i == 0), (eof_last && i == n - 1), bits[i], expm[i]);
   endtask

   task automatic frame_exp(input logic [19:0] c, input logic fm_e, input logic al_e);
      frm_t f;
      f.cnt = c; f.fm = fm_e; f.al = al_e;
      exp_frm_q.push_back(f);
   endtask

   task automatic hold_chk(input logic [19:0] c, input logic fm_e, input logic al_e);
      chk_cnt = c; chk_fm = fm_e; chk_al = al_e;
      chk_req++;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic busy_frame(input logic al_e);
      frame_exp(20'd5, 1'b1, al_e);
      seq(6, 16'h003F, 16'h003E, 1'b1, 1'b1);
   endtask

   task automatic quiet_frame(input logic al_e);
      frame_exp(20'd0, 1'b0, al_e);
      seq(3, 16'h0000, 16'h0000, 1'b1, 1'b1);
   endtask

   initial begin : stimulus
      rst = 1'b1; enable = 1'b0; pix_valid = 1'b0; sol = 1'b0; sof = 1'b0; eof = 1'b0;
      md = 1'b0; thr = 20'd2;
      idle(3);
      hold_chk(20'd0, 1'b0, 1'b0);
      rst = 1'b0;
      idle(2);

      // Warm-up frame: line filter example, then a line starting with motion after a moving tail.
      frame_exp(20'd3, 1'b1, 1'b0);
      seq(6, 16'b10_1110, 16'b00_1100, 1'b1, 1'b0);
      seq(2, 16'b11, 16'b10, 1'b0, 1'b1);

      busy_frame(1'b0);
      busy_frame(1'b0);
      busy_frame(1'b1);
      quiet_frame(1'b1);
      quiet_frame(1'b0);

      // Interrupted arming sequence.
      busy_frame(1'b0);
      busy_frame(1'b0);
      quiet_frame(1'b0);
      busy_frame(1'b0);
      busy_frame(1'b0);
      busy_frame(1'b1);
      idle(2);

      // Disabled pixels, including eof, must be invisible.
      seq(3, 16'h0007, 16'h0006, 1'b1, 1'b0);
      px(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      px(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      idle(2);
      hold_chk(20'd5, 1'b1, 1'b1);

      // Reset mid-frame while alarmed.
      rst = 1'b1;
      idle(1);
      hold_chk(20'd0, 1'b0, 1'b0);
      rst = 1'b0;
      idle(1);

      // Fresh warm-up with a one-pixel frame.
      frame_exp(20'd0, 1'b0, 1'b0);
      seq(1, 16'h0001, 16'h0000, 1'b1, 1'b1);
      // Partial frame discarded by a new sof.
      frame_exp(20'd2, 1'b1, 1'b0);
      seq(2, 16'h0003, 16'h0002, 1'b1, 1'b0);
      seq(3, 16'h0007, 16'h0006, 1'b1, 1'b1);
      // Zero threshold: a zero-count frame still counts as motion.
      thr = 20'd0;
      frame_exp(20'd0, 1'b1, 1'b0);
      seq(1, 16'h0001, 16'h0000, 1'b1, 1'b1);
      thr = 20'd2;
      busy_frame(1'b1);
      // Threshold boundary: count equal passes, one above fails.
      thr = 20'd5;
      busy_frame(1'b1);
      thr = 20'd6;
      frame_exp(20'd5, 1'b0, 1'b1);
      seq(6, 16'h003F, 16'h003E, 1'b1, 1'b1);
      thr = 20'd2;
      quiet_frame(1'b0);

      idle(3);
      tb_done = 1'b1;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no completion, required end within 200000 time units");
      $fatal(1);
   end

endmodule

// File: doc/motion_frame_alarm.md
MOTION_FRAME_ALARM -- requirements
Module: motion_frame_alarm

Interface
REQ-001 SHALL have parameter CNT_W, default 20, width of per-frame motion pixel count.
REQ-002 SHALL have parameter WARMUP_FRAMES, default 1, frames ignored after reset for background initialisation (range 1..255).
REQ-003 SHALL have parameter CONSEC_ON, default 3, consecutive motion frames needed to raise alarm (range 1..15).
REQ-004 SHALL have parameter CONSEC_OFF, default 2, consecutive quiet frames needed to drop alarm (range 1..15).
REQ-005 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-007 SHALL have port enable, input, 1, qualifies all pixel inputs; low means no pixel is accepted.
REQ-008 SHALL have port pix_valid, input, 1, a pixel's motion bit is present this cycle.
REQ-009 SHALL have port sol, input, 1, pixel is first of a line; valid only with pix_valid.
REQ-010 SHALL have port sof, input, 1, pixel is first of a frame (implies sol).
REQ-011 SHALL have port eof, input, 1, pixel is last of a frame.
REQ-012 SHALL have port motion_detected, input, 1, raw per-pixel motion bit from the sigma-delta stage.
REQ-013 SHALL have port count_threshold, input, CNT_W, minimum filtered count for a motion frame; sampled on the eof pixel.
REQ-014 SHALL have port mask_valid, output, 1, mask_out is valid.
REQ-015 SHALL have port mask_out, output, 1, filtered motion bit.
REQ-016 SHALL have port frame_done, output, 1, one-cycle pulse at frame end.
REQ-017 SHALL have port frame_motion_cnt, output, CNT_W, filtered count of the last completed frame.
REQ-018 SHALL have port frame_motion, output, 1, last completed frame met the threshold.
REQ-019 SHALL have port alarm, output, 1, debounced motion alarm.

Function
REQ-020 SHALL accept a pixel only when enable and pix_valid are both 1; sol/sof/eof/motion_detected are ignored otherwise.
REQ-021 SHALL compute filtered bit f = motion_detected AND prev, prev = motion bit of previous accepted pixel in the same line; prev treated as 0 on sol pixels.
REQ-022 SHALL present mask_valid=1 and mask_out=f exactly one cycle after acceptance; mask_valid=0 otherwise.
REQ-023 SHALL restart the frame count at a sof pixel with value f; other accepted pixels add f; count saturates at all-ones.
REQ-024 SHALL, one cycle after an accepted eof pixel, pulse frame_done and load frame_motion_cnt with the final count (including eof pixel) and frame_motion with (count >= count_threshold).
REQ-025 SHALL hold frame_motion_cnt and frame_motion until the next frame_done.
REQ-026 SHALL treat a pixel with sof and eof together as a one-pixel frame (count 0).
REQ-027 SHALL discard a partial count on a sof without a preceding eof; no frame_done.
REQ-028 SHALL run FSM states WARMUP, QUIET, ARMING, ALARM, RELEASING, advancing only on the frame_done cycle using that frame's frame_motion.
REQ-029 WARMUP: count frames; after WARMUP_FRAMES frames go to QUIET regardless of motion.
REQ-030 QUIET: motion -> ARMING with on_cnt=1, or ALARM if CONSEC_ON=1; else stay.
REQ-031 ARMING: motion -> on_cnt+1, ALARM when on_cnt reaches CONSEC_ON; quiet -> QUIET, on_cnt=0.
REQ-032 ALARM: quiet -> RELEASING with off_cnt=1, or QUIET if CONSEC_OFF=1; motion stays.
REQ-033 RELEASING: quiet -> off_cnt+1, QUIET when off_cnt reaches CONSEC_OFF; motion -> ALARM, off_cnt=0.
REQ-034 alarm SHALL be 1 exactly in ALARM and RELEASING, registered, changing on the same cycle as frame_done.
REQ-035 count_threshold=0 SHALL make every completed frame a motion frame.

Reset
REQ-036 On rst: mask_valid=0, mask_out=0, frame_done=0, frame_motion_cnt=0, frame_motion=0, alarm=0, FSM=WARMUP, all internal counts and prev=0.
REQ-037 rst mid-frame SHALL abandon the frame; no frame_done until a later accepted eof.

Verification
REQ-038 Line motion bits 0,1,1,1,0,1 (sol on first) -> mask_out 0,0,1,1,0,0, each one cycle later.
REQ-039 Bit 1 at end of line then sol pixel with bit 1 -> sol pixel mask_out=0.
REQ-040 Defaults, threshold=2; frame1 any, then frames with counts 5,5,5 -> alarm rises at 3rd motion frame's frame_done; then counts 0,0 -> alarm falls at 2nd quiet frame_done.
REQ-041 ARMING after 2 motion frames, quiet frame -> QUIET; next 2 motion frames keep alarm=0.
REQ-042 enable=0 during pixels with eof -> no frame_done, mask_valid=0, counts unchanged.
REQ-043 rst asserted mid-frame while alarm=1 -> all outputs 0 next cycle, FSM in WARMUP.
